// File: rtl/wb_pkg.sv
// Shared types and sizes for the integer writeback arbiter.
// Optional build macro: WB_FWD_EN (enables bypass from the register-file write port).
package wb_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RW   = $clog2(NREG);

   // One writeback request: used by both result channels and the output stage
   typedef struct packed {
      logic            valid;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] dat;
   } wb_req_t;

   // Round-robin pointer: names the channel that wins the next contested cycle
   typedef enum logic {
      RR_ALU = 1'b0,
      RR_LSU = 1'b1
   } rr_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: busy bit per architectural register, set when an
// instruction with a destination issues, cleared when the register file is
// written. Produces the decode stall and, with WB_FWD_EN defined, a bypass of
// the value currently being written.
module wb_scoreboard
   import wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid_i,
   input  logic            issue_we_i,
   input  logic [RW-1:0]   issue_rd_i,
   input  logic [RW-1:0]   rs1_i,
   input  logic [RW-1:0]   rs2_i,
   input  logic            rf_en_i,
   input  logic [RW-1:0]   rf_rd_i,
   input  logic [XLEN-1:0] rf_dat_i,
   output logic            hazard_o,
   output logic            fwd_rs1_hit_o,
   output logic            fwd_rs2_hit_o,
   output logic [XLEN-1:0] fwd_rs1_dat_o,
   output logic [XLEN-1:0] fwd_rs2_dat_o
);

   logic [NREG-1:0] r_busy;
   logic            w_set;
   logic            w_fwd1;
   logic            w_fwd2;
   logic            w_raw1;
   logic            w_raw2;
   logic            w_waw;

   // Only an accepted instruction with a real destination reserves a register;
   // x0 is never reserved, so busy[0] stays 0 from reset onwards.
   assign w_set = issue_valid_i && !hazard_o && issue_we_i && (issue_rd_i != '0);

`ifdef WB_FWD_EN
   // A source that matches the register being written this cycle can take the
   // write data directly instead of waiting for busy to clear.
   assign w_fwd1 = rf_en_i && (rf_rd_i != '0) && (rs1_i == rf_rd_i);
   assign w_fwd2 = rf_en_i && (rf_rd_i != '0) && (rs2_i == rf_rd_i);
`else
   assign w_fwd1 = 1'b0;
   assign w_fwd2 = 1'b0;
`endif

   assign w_raw1 = r_busy[rs1_i] && !w_fwd1;
   assign w_raw2 = r_busy[rs2_i] && !w_fwd2;
   // WAW is never bypassed: the older write must land before a new owner issues
   assign w_waw  = issue_we_i && r_busy[issue_rd_i];

   assign hazard_o      = issue_valid_i && (w_raw1 || w_raw2 || w_waw);
   assign fwd_rs1_hit_o = w_fwd1;
   assign fwd_rs2_hit_o = w_fwd2;
   assign fwd_rs1_dat_o = w_fwd1 ? rf_dat_i : '0;
   assign fwd_rs2_dat_o = w_fwd2 ? rf_dat_i : '0;

   // Busy vector update; the set is written last so it wins over a same-index
   // clear (the issuing instruction is younger than the retiring write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         if (rf_en_i) begin
            r_busy[rf_rd_i] <= 1'b0;
         end
         if (w_set) begin
            r_busy[issue_rd_i] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of the ALU / LSU results per cycle with a 1-bit
// round-robin pointer, registers it into the register-file write stage and
// hosts the pending-write scoreboard.
// Optional build macro: WB_FWD_EN (bypass of the write-port value to decode).
module wb_arbiter
   import wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid_i,
   input  logic            issue_we_i,
   input  logic [RW-1:0]   issue_rd_i,
   input  logic [RW-1:0]   rs1_i,
   input  logic [RW-1:0]   rs2_i,
   output logic            issue_ready_o,
   output logic            hazard_o,
   input  logic            alu_valid_i,
   input  logic [RW-1:0]   alu_rd_i,
   input  logic [XLEN-1:0] alu_dat_i,
   output logic            alu_ready_o,
   input  logic            lsu_valid_i,
   input  logic [RW-1:0]   lsu_rd_i,
   input  logic [XLEN-1:0] lsu_dat_i,
   output logic            lsu_ready_o,
   output logic            rf_en_o,
   output logic [RW-1:0]   rf_rd_o,
   output logic [XLEN-1:0] rf_dat_o,
   output logic            fwd_rs1_hit_o,
   output logic            fwd_rs2_hit_o,
   output logic [XLEN-1:0] fwd_rs1_dat_o,
   output logic [XLEN-1:0] fwd_rs2_dat_o
);

   rr_t     r_rr;
   wb_req_t r_out;
   wb_req_t w_alu;
   wb_req_t w_lsu;
   wb_req_t w_win;
   logic    w_alu_gnt;
   logic    w_lsu_gnt;
   logic    w_contested;

   assign w_alu = '{valid: alu_valid_i, rd: alu_rd_i, dat: alu_dat_i};
   assign w_lsu = '{valid: lsu_valid_i, rd: lsu_rd_i, dat: lsu_dat_i};

   // A channel is granted when it is the only one presenting, or when both are
   // and the pointer names it. Gating with the channel's own valid keeps the
   // two readies mutually exclusive even when both channels are idle.
   assign w_contested = alu_valid_i && lsu_valid_i;
   assign w_alu_gnt   = alu_valid_i && (!lsu_valid_i || (r_rr == RR_ALU));
   assign w_lsu_gnt   = lsu_valid_i && (!alu_valid_i || (r_rr == RR_LSU));
   assign alu_ready_o = w_alu_gnt;
   assign lsu_ready_o = w_lsu_gnt;

   // Winner mux; valid is low when nothing was granted
   assign w_win = w_lsu_gnt ? w_lsu : w_alu;

   // Pointer moves only on a contested grant, towards the loser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr <= RR_ALU;
      end else if (w_contested) begin
         r_rr <= w_alu_gnt ? RR_LSU : RR_ALU;
      end
   end

   // Output stage: the register file never stalls, so it reloads every cycle;
   // index/data only change when a result is actually captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
      end else begin
         r_out.valid <= w_win.valid;
         if (w_win.valid) begin
            r_out.rd  <= w_win.rd;
            r_out.dat <= w_win.dat;
         end
      end
   end

   // Writes to x0 are accepted and tracked but never reach the register file
   assign rf_en_o  = r_out.valid && (r_out.rd != '0);
   assign rf_rd_o  = r_out.rd;
   assign rf_dat_o = r_out.dat;

   assign issue_ready_o = !hazard_o;

   wb_scoreboard u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid_i (issue_valid_i),
      .issue_we_i    (issue_we_i),
      .issue_rd_i    (issue_rd_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .rf_en_i       (rf_en_o),
      .rf_rd_i       (rf_rd_o),
      .rf_dat_i      (rf_dat_o),
      .hazard_o      (hazard_o),
      .fwd_rs1_hit_o (fwd_rs1_hit_o),
      .fwd_rs2_hit_o (fwd_rs2_hit_o),
      .fwd_rs1_dat_o (fwd_rs1_dat_o),
      .fwd_rs2_dat_o (fwd_rs2_dat_o)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, a behavioural model of the
// arbiter/scoreboard checked every cycle, plus literal expectations per test.
// Build with +define+WB_FWD_EN to cover the bypass variant.
module tb_wb_arbiter;
   import wb_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            issue_valid, issue_we;
   logic [RW-1:0]   issue_rd, rs1, rs2;
   logic            issue_ready_o, hazard_o;
   logic            alu_valid, lsu_valid;
   logic [RW-1:0]   alu_rd, lsu_rd;
   logic [XLEN-1:0] alu_dat, lsu_dat;
   logic            alu_ready_o, lsu_ready_o;
   logic            rf_en_o;
   logic [RW-1:0]   rf_rd_o;
   logic [XLEN-1:0] rf_dat_o;
   logic            fwd_rs1_hit_o, fwd_rs2_hit_o;
   logic [XLEN-1:0] fwd_rs1_dat_o, fwd_rs2_dat_o;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid_i (issue_valid),
      .issue_we_i    (issue_we),
      .issue_rd_i    (issue_rd),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .issue_ready_o (issue_ready_o),
      .hazard_o      (hazard_o),
      .alu_valid_i   (alu_valid),
      .alu_rd_i      (alu_rd),
      .alu_dat_i     (alu_dat),
      .alu_ready_o   (alu_ready_o),
      .lsu_valid_i   (lsu_valid),
      .lsu_rd_i      (lsu_rd),
      .lsu_dat_i     (lsu_dat),
      .lsu_ready_o   (lsu_ready_o),
      .rf_en_o       (rf_en_o),
      .rf_rd_o       (rf_rd_o),
      .rf_dat_o      (rf_dat_o),
      .fwd_rs1_hit_o (fwd_rs1_hit_o),
      .fwd_rs2_hit_o (fwd_rs2_hit_o),
      .fwd_rs1_dat_o (fwd_rs1_dat_o),
      .fwd_rs2_dat_o (fwd_rs2_dat_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit              m_favour_lsu;   // which channel gets the next tie
   bit              m_busy [NREG];
   bit              m_wr_pending;   // a captured result is in the write stage
   logic [RW-1:0]   m_wr_rd;
   logic [XLEN-1:0] m_wr_dat;

   // 0 = nobody, 1 = ALU, 2 = LSU
   function automatic int m_winner();
      if (alu_valid && lsu_valid) return m_favour_lsu ? 2 : 1;
      if (alu_valid) return 1;
      if (lsu_valid) return 2;
      return 0;
   endfunction

   function automatic bit m_writing();
      return m_wr_pending && (m_wr_rd != 0);
   endfunction

   function automatic bit m_fwd(input logic [RW-1:0] rs);
`ifdef WB_FWD_EN
      return m_writing() && (rs == m_wr_rd);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_hazard();
      bit raw;
      raw = (m_busy[rs1] && !m_fwd(rs1)) || (m_busy[rs2] && !m_fwd(rs2));
      return issue_valid && (raw || (issue_we && m_busy[issue_rd]));
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_favour_lsu = 1'b0;
            m_wr_pending = 1'b0;
            m_wr_rd      = '0;
            m_wr_dat     = '0;
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
         end else begin
            int w;
            bit haz;
            w   = m_winner();
            haz = m_hazard();
            if (alu_valid && lsu_valid) m_favour_lsu = (w == 1);
            if (m_writing()) m_busy[m_wr_rd] = 1'b0;
            if (issue_valid && !haz && issue_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_wr_pending = (w != 0);
            if (w == 1) begin
               m_wr_rd  = alu_rd;
               m_wr_dat = alu_dat;
               $display("xfer alu rd=%0d dat=0x%08h t=%0t", alu_rd, alu_dat, $time);
            end else if (w == 2) begin
               m_wr_rd  = lsu_rd;
               m_wr_dat = lsu_dat;
               $display("xfer lsu rd=%0d dat=0x%08h t=%0t", lsu_rd, lsu_dat, $time);
            end
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         chk("alu_ready",   alu_ready_o,   32'(m_winner() == 1));
         chk("lsu_ready",   lsu_ready_o,   32'(m_winner() == 2));
         chk("rf_en",       rf_en_o,       32'(m_writing()));
         chk("rf_rd",       rf_rd_o,       32'(m_wr_rd));
         chk("rf_dat",      rf_dat_o,      m_wr_dat);
         chk("hazard",      hazard_o,      32'(m_hazard()));
         chk("issue_ready", issue_ready_o, 32'(!m_hazard()));
         chk("fwd1_hit",    fwd_rs1_hit_o, 32'(m_fwd(rs1)));
         chk("fwd2_hit",    fwd_rs2_hit_o, 32'(m_fwd(rs2)));
         chk("fwd1_dat",    fwd_rs1_dat_o, m_fwd(rs1) ? m_wr_dat : 32'h0);
         chk("fwd2_dat",    fwd_rs2_dat_o, m_fwd(rs2) ? m_wr_dat : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b0;
      issue_valid = 0; issue_we = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_dat = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_dat = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step(); #1;
      chk("rst_rf_en", rf_en_o, 0);
      chk("rst_rf_rd", rf_rd_o, 0);
      chk("rst_rf_dat", rf_dat_o, 0);
      chk("rst_hazard", hazard_o, 0);
      chk("rst_fwd1", fwd_rs1_hit_o, 0);

      // ALU only
      alu_valid = 1; alu_rd = 5; alu_dat = 32'h1234; #1;
      chk("t1_alu_ready", alu_ready_o, 1);
      chk("t1_lsu_ready", lsu_ready_o, 0);
      step(); alu_valid = 0; #1;
      chk("t1_rf_en", rf_en_o, 1);
      chk("t1_rf_rd", rf_rd_o, 5);
      chk("t1_rf_dat", rf_dat_o, 32'h1234);
      chk("t1_model_rd", 32'(m_wr_rd), 5);
      step(); #1;
      chk("t1_rf_en_low", rf_en_o, 0);

      // Contested for 4 cycles: ALU, LSU, ALU, LSU
      alu_valid = 1; alu_rd = 3; alu_dat = 32'hA0A0_0003;
      lsu_valid = 1; lsu_rd = 4; lsu_dat = 32'hB0B0_0004;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_alu_ready", alu_ready_o, 32'(i % 2 == 0));
         chk("t2_lsu_ready", lsu_ready_o, 32'(i % 2 == 1));
         step();
         if (i == 3) begin
            alu_valid = 0; lsu_valid = 0;
         end
         #1;
         chk("t2_rf_en", rf_en_o, 1);
         chk("t2_rf_rd", rf_rd_o, (i % 2 == 0) ? 32'd3 : 32'd4);
         chk("t2_rf_dat", rf_dat_o, (i % 2 == 0) ? 32'hA0A0_0003 : 32'hB0B0_0004);
      end
      step();

      // RAW on x7
      issue_valid = 1; issue_we = 1; issue_rd = 7; rs1 = 0; rs2 = 0; #1;
      chk("t3_issue_ok", hazard_o, 0);
      step(); issue_we = 0; issue_rd = 0; rs1 = 7; #1;
      chk("t3_haz", hazard_o, 1);
      chk("t3_ready", issue_ready_o, 0);
      step(); #1;
      chk("t3_haz_hold", hazard_o, 1);
      alu_valid = 1; alu_rd = 7; alu_dat = 32'hCAFE_0007;
      step(); alu_valid = 0; #1;
      chk("t3_wr_en", rf_en_o, 1);
      chk("t3_wr_rd", rf_rd_o, 7);
`ifdef WB_FWD_EN
      chk("t3_haz_wr", hazard_o, 0);
      chk("t3_fwd_hit", fwd_rs1_hit_o, 1);
      chk("t3_fwd_dat", fwd_rs1_dat_o, 32'hCAFE_0007);
`else
      chk("t3_haz_wr", hazard_o, 1);
      chk("t3_fwd_hit", fwd_rs1_hit_o, 0);
`endif
      step(); #1;
      chk("t3_haz_after", hazard_o, 0);
      issue_valid = 0; rs1 = 0;

      // LSU write to x0, with an issue targeting x0 alongside
      lsu_valid = 1; lsu_rd = 0; lsu_dat = 32'hFFFF_FFFF;
      issue_valid = 1; issue_we = 1; issue_rd = 0; #1;
      chk("t4_lsu_ready", lsu_ready_o, 1);
      chk("t4_haz", hazard_o, 0);
      step(); lsu_valid = 0; issue_we = 0; #1;
      chk("t4_rf_en", rf_en_o, 0);
      chk("t4_rf_rd", rf_rd_o, 0);
      chk("t4_rf_dat", rf_dat_o, 32'hFFFF_FFFF);
      chk("t4_haz_x0", hazard_o, 0);
      chk("t4_model_busy0", 32'(m_busy[0]), 0);
      step(); issue_valid = 0;

      // Same-cycle set and clear on x9
      alu_valid = 1; alu_rd = 9; alu_dat = 32'h0000_0009;
      step(); alu_valid = 0;
      issue_valid = 1; issue_we = 1; issue_rd = 9; #1;
      chk("t5_rf_en", rf_en_o, 1);
      chk("t5_rf_rd", rf_rd_o, 9);
      chk("t5_haz", hazard_o, 0);
      step(); issue_we = 0; issue_rd = 0; rs2 = 9; #1;
      chk("t5_haz_rs2", hazard_o, 1);
      chk("t5_model_busy9", 32'(m_busy[9]), 1);
      step(); #1;
      chk("t5_haz_rs2_hold", hazard_o, 1);
      issue_valid = 0; rs2 = 0;

      // Reset with busy[2] set and the output stage full
      issue_valid = 1; issue_we = 1; issue_rd = 2;
      alu_valid = 1; alu_rd = 11; alu_dat = 32'h0000_BEEF; #1;
      chk("t6_issue_ok", hazard_o, 0);
      step(); issue_we = 0; issue_rd = 0; rs1 = 2; alu_valid = 0; #1;
      chk("t6_rf_en", rf_en_o, 1);
      chk("t6_haz", hazard_o, 1);
      rst_n = 1'b0; #1;
      chk("t6_rst_rf_en", rf_en_o, 0);
      chk("t6_rst_rf_rd", rf_rd_o, 0);
      chk("t6_rst_rf_dat", rf_dat_o, 0);
      #10 rst_n = 1'b1;
      step();
      issue_valid = 1; issue_we = 1; issue_rd = 2; rs1 = 2; rs2 = 9; #1;
      chk("t6_haz_after_rst", hazard_o, 0);
      step(); issue_valid = 0; issue_we = 0; rs1 = 0; rs2 = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
